// File: rtl/ps2_pkg.sv
// ps2_pkg: shared PS/2 byte constants, frame FSM state type and parity helper.
// Revision: 1.0 - initial release
`default_nettype none

package ps2_pkg;

  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_BRK = 8'hF0;
  localparam logic [7:0] NO_KEY  = 8'h00;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } ps2_state_t;

  // PS/2 uses odd parity over the 8 data bits plus the parity bit.
  function automatic logic parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

`default_nettype wire

// File: rtl/ps2_sync_edge.sv
// ps2_sync_edge: 2-FF synchronisers, optional glitch filter (PS2_GLITCH_FILTER_EN)
// and registered falling-edge strobe for the PS/2 clock.  Revision: 1.0
`default_nettype none

module ps2_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic ps2_clk,
  input  logic ps2_data,
  output logic fall,
  output logic data_s
);

  logic [1:0] clk_sync_q;
  logic [1:0] data_sync_q;
  logic       level_prev_q;
  logic       fall_q;
  logic       data_s_q;
  logic       level;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync_q  <= 2'b11;
      data_sync_q <= 2'b11;
    end else begin
      clk_sync_q  <= {clk_sync_q[0], ps2_clk};
      data_sync_q <= {data_sync_q[0], ps2_data};
    end
  end

`ifdef PS2_GLITCH_FILTER_EN
  logic       filt_q, filt_d;
  logic [2:0] filt_cnt_q, filt_cnt_d;

  // The filtered level flips only after 8 consecutive cycles of disagreement.
  always_comb begin
    filt_d     = filt_q;
    filt_cnt_d = 3'd0;
    if (clk_sync_q[1] != filt_q) begin
      if (filt_cnt_q == 3'd7) begin
        filt_d = clk_sync_q[1];
      end else begin
        filt_cnt_d = filt_cnt_q + 3'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt_q     <= 1'b1;
      filt_cnt_q <= 3'd0;
    end else begin
      filt_q     <= filt_d;
      filt_cnt_q <= filt_cnt_d;
    end
  end

  assign level = filt_q;
`else
  assign level = clk_sync_q[1];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_prev_q <= 1'b1;
      fall_q       <= 1'b0;
      data_s_q     <= 1'b1;
    end else begin
      level_prev_q <= level;
      fall_q       <= level_prev_q & ~level;
      data_s_q     <= data_sync_q[1];
    end
  end

  assign fall   = fall_q;
  assign data_s = data_s_q;

endmodule

`default_nettype wire

// File: rtl/ps2_note_decoder.sv
// ps2_note_decoder: PS/2 frame receiver and make/break handler producing the held
// note scan code. Optional macro: PS2_GLITCH_FILTER_EN.  Revision: 1.0
`default_nettype none

module ps2_note_decoder
  import ps2_pkg::*;
#(
  parameter int unsigned CLK_HZ      = 100_000_000,
  parameter int unsigned TIMEOUT_CYC = 100_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] codigo,
  output logic       code_valid,
  output logic       frame_err
);

  localparam int unsigned CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYC - 1);

  generate
    if (CLK_HZ < 1_000_000 || TIMEOUT_CYC < 2) begin : g_bad_cfg
      $error("ps2_note_decoder: CLK_HZ or TIMEOUT_CYC out of range");
    end
  endgenerate

  logic fall;
  logic data_s;

  ps2_sync_edge u_sync_edge (
    .clk     (clk),
    .rst_n   (rst_n),
    .ps2_clk (ps2_clk),
    .ps2_data(ps2_data),
    .fall    (fall),
    .data_s  (data_s)
  );

  ps2_state_t       state_q,  state_d;
  logic [7:0]       shift_q,  shift_d;
  logic [2:0]       bitcnt_q, bitcnt_d;
  logic             parity_q, parity_d;
  logic [CNT_W-1:0] tocnt_q,  tocnt_d;
  logic             ext_q,    ext_d;
  logic             brk_q,    brk_d;
  logic [7:0]       codigo_q, codigo_d;
  logic             cv_q,     cv_d;
  logic             fe_q,     fe_d;
  logic [7:0]       new_code;
  logic             timeout;

  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    bitcnt_d = bitcnt_q;
    parity_d = parity_q;
    tocnt_d  = tocnt_q;
    ext_d    = ext_q;
    brk_d    = brk_q;
    codigo_d = codigo_q;
    cv_d     = 1'b0;
    fe_d     = 1'b0;
    new_code = codigo_q;
    timeout  = (state_q != IDLE) && (tocnt_q == TO_LAST) && !fall;

    if (fall) begin
      tocnt_d = '0;
    end else if (state_q != IDLE && tocnt_q != TO_LAST) begin
      tocnt_d = tocnt_q + 1'b1;
    end

    if (timeout) begin
      state_d = IDLE;
      fe_d    = 1'b1;
      ext_d   = 1'b0;
      brk_d   = 1'b0;
    end else if (fall) begin
      case (state_q)
        IDLE: begin
          if (!data_s) begin
            state_d  = DATA;
            bitcnt_d = 3'd0;
          end
        end
        DATA: begin
          shift_d  = {data_s, shift_q[7:1]};
          bitcnt_d = bitcnt_q + 3'd1;
          if (bitcnt_q == 3'd7) begin
            state_d = PARITY;
          end
        end
        PARITY: begin
          parity_d = data_s;
          state_d  = STOP;
        end
        STOP: begin
          state_d = IDLE;
          if (data_s && parity_ok(shift_q, parity_q)) begin
            if (shift_q == PS2_EXT) begin
              ext_d = 1'b1;
            end else if (shift_q == PS2_BRK) begin
              brk_d = 1'b1;
            end else if (brk_q) begin
              // Only releasing the key we are holding silences the note.
              if (shift_q == codigo_q) begin
                new_code = NO_KEY;
              end
              brk_d = 1'b0;
              ext_d = 1'b0;
            end else if (ext_q) begin
              ext_d = 1'b0;
            end else begin
              new_code = shift_q;
            end
            if (new_code != codigo_q) begin
              codigo_d = new_code;
              cv_d     = 1'b1;
            end
          end else begin
            fe_d  = 1'b1;
            ext_d = 1'b0;
            brk_d = 1'b0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      shift_q  <= 8'h00;
      bitcnt_q <= 3'd0;
      parity_q <= 1'b0;
      tocnt_q  <= '0;
      ext_q    <= 1'b0;
      brk_q    <= 1'b0;
      codigo_q <= NO_KEY;
      cv_q     <= 1'b0;
      fe_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      bitcnt_q <= bitcnt_d;
      parity_q <= parity_d;
      tocnt_q  <= tocnt_d;
      ext_q    <= ext_d;
      brk_q    <= brk_d;
      codigo_q <= codigo_d;
      cv_q     <= cv_d;
      fe_q     <= fe_d;
    end
  end

  assign codigo     = codigo_q;
  assign code_valid = cv_q;
  assign frame_err  = fe_q;

endmodule

`default_nettype wire

// File: tb/tb_ps2_note_decoder.sv
// tb_ps2_note_decoder: directed-frame bench for ps2_note_decoder with a short timeout.
// Revision: 1.0
`default_nettype none

module tb_ps2_note_decoder;

  localparam int TO = 400;
  localparam int HP = 20;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] codigo;
  logic       code_valid;
  logic       frame_err;

  int checks = 0;
  int errors = 0;
  int cv_cnt = 0;
  int fe_cnt = 0;
  int cv0, fe0, n;

  ps2_note_decoder #(.CLK_HZ(100_000_000), .TIMEOUT_CYC(TO)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .codigo    (codigo),
    .code_valid(code_valid),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n) begin
      if (code_valid) cv_cnt++;
      if (frame_err) fe_cnt++;
      if (code_valid || frame_err) begin
        checks++;
        assert (!(code_valid && frame_err)) else begin
          errors++;
          $error("FAIL pulse_overlap: observed cv=%0b fe=%0b required not both", code_valid, frame_err);
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    ps2_data = b;
    wait_cyc(HP);
    ps2_clk = 1'b0;
    wait_cyc(HP);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic flip_par = 1'b0,
                            input logic stop = 1'b1);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(~^d ^ flip_par);
    send_bit(stop);
    ps2_data = 1'b1;
    wait_cyc(HP);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: observed no finish, required finish before 5 ms");
    $fatal(1, "watchdog");
  end

  initial begin
    wait_cyc(5);
    chk("reset_codigo", 32'(codigo), 32'h00);
    chk("reset_cv", 32'(code_valid), 32'h0);
    chk("reset_fe", 32'(frame_err), 32'h0);
    rst_n = 1'b1;
    wait_cyc(5);

    // Make 15
    cv0 = cv_cnt; fe0 = fe_cnt;
    send_frame(8'h15);
    chk("make15_codigo", 32'(codigo), 32'h15);
    chk("make15_cv", 32'(cv_cnt - cv0), 32'd1);
    chk("make15_fe", 32'(fe_cnt - fe0), 32'd0);

    // Typematic repeat then release
    cv0 = cv_cnt;
    send_frame(8'h15);
    chk("repeat_cv", 32'(cv_cnt - cv0), 32'd0);
    chk("repeat_codigo", 32'(codigo), 32'h15);
    cv0 = cv_cnt;
    send_frame(8'hF0);
    send_frame(8'h15);
    chk("break15_codigo", 32'(codigo), 32'h00);
    chk("break15_cv", 32'(cv_cnt - cv0), 32'd1);

    // Two presses then a stale break
    cv0 = cv_cnt;
    send_frame(8'h1D);
    send_frame(8'h24);
    send_frame(8'hF0);
    send_frame(8'h1D);
    chk("stale_codigo", 32'(codigo), 32'h24);
    chk("stale_cv", 32'(cv_cnt - cv0), 32'd2);

    // Parity error, extended key, bad stop bit
    fe0 = fe_cnt;
    send_frame(8'h2D, 1'b1);
    chk("parity_fe", 32'(fe_cnt - fe0), 32'd1);
    chk("parity_codigo", 32'(codigo), 32'h24);
    cv0 = cv_cnt; fe0 = fe_cnt;
    send_frame(8'hE0);
    send_frame(8'h74);
    chk("ext_codigo", 32'(codigo), 32'h24);
    chk("ext_cv", 32'(cv_cnt - cv0), 32'd0);
    chk("ext_fe", 32'(fe_cnt - fe0), 32'd0);
    fe0 = fe_cnt;
    send_frame(8'h33, 1'b0, 1'b0);
    chk("stop_fe", 32'(fe_cnt - fe0), 32'd1);
    chk("stop_codigo", 32'(codigo), 32'h24);

    // Truncated frame: start + 4 data bits, then the bus goes quiet
    fe0 = fe_cnt;
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    ps2_data = 1'b0;
    wait_cyc(HP);
    ps2_clk = 1'b0;
    n = 0;
    while (n < 3 * TO) begin
      @(negedge clk);
      n++;
      if (n == HP) ps2_clk = 1'b1;
      if (frame_err) break;
    end
    ps2_data = 1'b1;
    // 3-cycle edge latency, TO idle cycles, then the registered pulse
    chk("timeout_latency", 32'(n), 32'(TO + 4));
    wait_cyc(5);
    chk("timeout_fe", 32'(fe_cnt - fe0), 32'd1);
    send_frame(8'h43);
    chk("after_to_codigo", 32'(codigo), 32'h43);

    // Asynchronous reset mid-frame
    send_frame(8'h35);
    chk("pre_rst_codigo", 32'(codigo), 32'h35);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    wait_cyc(3);
    #2 rst_n = 1'b0;
    #1 chk("async_rst_codigo", 32'(codigo), 32'h00);
    wait_cyc(3);
    rst_n = 1'b1;
    fe0 = fe_cnt; cv0 = cv_cnt;
    wait_cyc(TO + 50);
    chk("post_rst_fe", 32'(fe_cnt - fe0), 32'd0);
    send_frame(8'h3C);
    chk("post_rst_codigo", 32'(codigo), 32'h3C);
    chk("post_rst_cv", 32'(cv_cnt - cv0), 32'd1);

    wait_cyc(10);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
